// File: rtl/scroll_message_engine_if.sv
// Bus between the digit-scan logic / message writer and the message scroller.
// The master drives scan, mode and write strobes; the slave returns character, window start and step.
interface scroll_message_engine_if #(
    parameter int CHAR_W  = 4,
    parameter int MSG_LEN = 16,
    parameter int DIGITS  = 4
);
    localparam int AW = $clog2(MSG_LEN);
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [DW-1:0]     digit_sel;
    logic [1:0]        mode;
    logic              pause;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [CHAR_W-1:0] wr_data;
    logic [CHAR_W-1:0] char_out;
    logic [AW-1:0]     pos;
    logic              step;

    modport master (
        output digit_sel, mode, pause, wr_en, wr_addr, wr_data,
        input  char_out, pos, step
    );

    modport slave (
        input  digit_sel, mode, pause, wr_en, wr_addr, wr_data,
        output char_out, pos, step
    );
endinterface

// File: rtl/scroll_message_engine.sv
// Message scroller: writable MSG_LEN-entry character store with a DIGITS-wide window
// that advances on a programmable tick (static, left, right, ping-pong), with pause.
module scroll_message_engine #(
    parameter int CHAR_W  = 4,
    parameter int MSG_LEN = 16,
    parameter int DIGITS  = 4,
    parameter int PERIOD  = 8388608
) (
    input  logic                     clk,
    input  logic                     reset,
    scroll_message_engine_if.slave   bus
);
    localparam int AW  = $clog2(MSG_LEN);
    localparam int DW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int TW  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int LIM = MSG_LEN - DIGITS;

    localparam logic [TW-1:0] TIMER_LAST = TW'(PERIOD - 1);
    localparam logic [AW-1:0] POS_LAST   = AW'(MSG_LEN - 1);
    localparam logic [AW-1:0] POS_LIM    = AW'(LIM);
    localparam logic [AW:0]   MSG_LEN_X  = (AW + 1)'(MSG_LEN);
    localparam logic [DW:0]   DIGITS_X   = (DW + 1)'(DIGITS);

    typedef enum logic {
        DIR_UP,
        DIR_DOWN
    } dir_t;

    logic [CHAR_W-1:0] r_msg [MSG_LEN];
    logic [AW-1:0]     r_pos;
    dir_t              r_dir;
    logic [TW-1:0]     r_timer;
    logic [CHAR_W-1:0] r_charOut;
    logic              r_step;

    logic              w_tick;
    logic              w_wrOk;
    logic [AW-1:0]     w_posInc;
    logic [AW-1:0]     w_posDec;
    logic [AW-1:0]     w_nextPos;
    dir_t              w_nextDir;
    logic [DW-1:0]     w_digit;
    logic [AW:0]       w_sum;
    logic [AW-1:0]     w_rdAddr;

    assign w_tick   = (r_timer == TIMER_LAST) && !bus.pause;
    assign w_wrOk   = bus.wr_en && ({1'b0, bus.wr_addr} < MSG_LEN_X);
    assign w_posInc = (r_pos == POS_LAST) ? '0 : r_pos + 1'b1;
    assign w_posDec = (r_pos == '0) ? POS_LAST : r_pos - 1'b1;

    // The window sum never exceeds 2*MSG_LEN-2, so one conditional subtraction wraps it.
    assign w_digit  = ({1'b0, bus.digit_sel} >= DIGITS_X) ? '0 : bus.digit_sel;
    assign w_sum    = {1'b0, r_pos} + (AW + 1)'(w_digit);
    assign w_rdAddr = (w_sum >= MSG_LEN_X) ? AW'(w_sum - MSG_LEN_X) : w_sum[AW-1:0];

    always_comb begin
        w_nextPos = r_pos;
        w_nextDir = r_dir;
        case (bus.mode)
            2'b01: w_nextPos = w_posInc;
            2'b10: w_nextPos = w_posDec;
            2'b11: begin
                // A window left beyond the bounce limit by another mode snaps back and heads down.
                if (r_pos > POS_LIM) begin
                    w_nextPos = POS_LIM;
                    w_nextDir = DIR_DOWN;
                end else if (LIM == 0) begin
                    w_nextPos = r_pos;
                end else if (r_dir == DIR_UP) begin
                    if (r_pos < POS_LIM) begin
                        w_nextPos = w_posInc;
                    end else begin
                        w_nextPos = w_posDec;
                        w_nextDir = DIR_DOWN;
                    end
                end else begin
                    if (r_pos != '0) begin
                        w_nextPos = w_posDec;
                    end else begin
                        w_nextPos = w_posInc;
                        w_nextDir = DIR_UP;
                    end
                end
            end
            default: w_nextPos = r_pos;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pos     <= '0;
            r_dir     <= DIR_UP;
            r_timer   <= '0;
            r_charOut <= '0;
            r_step    <= 1'b0;
            for (int i = 0; i < MSG_LEN; i++) begin
                r_msg[i] <= '0;
            end
        end else begin
            if (!bus.pause) begin
                r_timer <= (r_timer == TIMER_LAST) ? '0 : r_timer + 1'b1;
            end
            if (w_tick) begin
                r_pos <= w_nextPos;
                r_dir <= w_nextDir;
            end
            r_step    <= w_tick && (w_nextPos != r_pos);
            r_charOut <= r_msg[w_rdAddr];
            if (w_wrOk) begin
                r_msg[bus.wr_addr] <= bus.wr_data;
            end
        end
    end

    assign bus.char_out = r_charOut;
    assign bus.pos      = r_pos;
    assign bus.step     = r_step;
endmodule

// File: tb/tb_scroll_message_engine.sv
// Directed bench for scroll_message_engine with MSG_LEN=6, DIGITS=4, PERIOD=4
// and the message 1..6; expected values are hand-computed constants.
module tb_scroll_message_engine;
    localparam int CHAR_W  = 4;
    localparam int MSG_LEN = 6;
    localparam int DIGITS  = 4;
    localparam int PERIOD  = 4;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    scroll_message_engine_if #(
        .CHAR_W (CHAR_W),
        .MSG_LEN(MSG_LEN),
        .DIGITS (DIGITS)
    ) bus ();

    scroll_message_engine #(
        .CHAR_W (CHAR_W),
        .MSG_LEN(MSG_LEN),
        .DIGITS (DIGITS),
        .PERIOD (PERIOD)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] addr, input logic [3:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        tick1();
        bus.wr_en   = 1'b0;
    endtask

    task automatic loadMessage();
        for (int i = 0; i < MSG_LEN; i++) begin
            applyStimulus(3'(i), 4'(i + 1));
        end
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        tick1();
        reset = 1'b0;
    endtask

    task automatic waitStep(output int n);
        n = 0;
        do begin
            tick1();
            n++;
        end while (bus.step !== 1'b1 && n < 20);
    endtask

    // Waits for the next step pulse, then checks it, the new pos and optionally the gap.
    task automatic checkStepPos(input string tag, input int expPos, input int expGap);
        int n;
        waitStep(n);
        checkOutput({tag, "_step"}, 32'(bus.step), 32'd1);
        checkOutput({tag, "_pos"}, 32'(bus.pos), 32'(expPos));
        if (expGap >= 0) begin
            checkOutput({tag, "_gap"}, 32'(n), 32'(expGap));
        end
    endtask

    task automatic readWindow(input string tag, input logic [15:0] exp4);
        for (int d = 0; d < DIGITS; d++) begin
            bus.digit_sel = 2'(d);
            tick1();
            checkOutput(tag, 32'(bus.char_out), 32'(exp4[4*(3-d) +: 4]));
        end
    endtask

    initial begin
        int stepSeen;
        int posMoves;
        int seqL [7];
        int seqR [4];
        int seqP [6];
        seqL = '{1, 2, 3, 4, 5, 0, 1};
        seqR = '{0, 5, 4, 3};
        seqP = '{1, 2, 1, 0, 1, 2};
        checks        = 0;
        failures      = 0;
        reset         = 1'b1;
        bus.digit_sel = '0;
        bus.mode      = 2'b00;
        bus.pause     = 1'b0;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        tick1();
        tick1();
        reset = 1'b0;

        // Reset state, static mode scan
        checkOutput("rst_pos", 32'(bus.pos), 32'd0);
        checkOutput("rst_char", 32'(bus.char_out), 32'd0);
        checkOutput("rst_step", 32'(bus.step), 32'd0);
        loadMessage();
        readWindow("static_read", 16'h1234);
        stepSeen = 0;
        posMoves = 0;
        for (int c = 0; c < 20; c++) begin
            tick1();
            if (bus.step !== 1'b0) stepSeen++;
            if (bus.pos !== 3'd0) posMoves++;
        end
        checkOutput("static_step_count", 32'(stepSeen), 32'd0);
        checkOutput("static_pos_moves", 32'(posMoves), 32'd0);

        // Scroll left, including a wrapped window at pos 4
        bus.mode = 2'b01;
        for (int i = 0; i < 7; i++) begin
            if (i == 4) begin
                checkOutput("left4_step", 32'(bus.step), 32'd1);
                checkOutput("left4_pos", 32'(bus.pos), 32'd5);
            end else begin
                checkStepPos($sformatf("left%0d", i), seqL[i], (i == 0) ? -1 : 4);
            end
            if (i == 3) readWindow("left_wrap_read", 16'h5612);
        end

        // Scroll right from pos 0
        bus.mode = 2'b10;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                checkOutput("right2_step", 32'(bus.step), 32'd1);
                checkOutput("right2_pos", 32'(bus.pos), 32'd4);
            end else begin
                checkStepPos($sformatf("right%0d", i), seqR[i], (i == 0) ? -1 : 4);
            end
            if (i == 1) readWindow("right_wrap_read", 16'h6123);
        end

        // Ping-pong from reset, then re-entry from beyond the limit
        bus.mode = 2'b11;
        pulseReset();
        for (int i = 0; i < 6; i++) begin
            checkStepPos($sformatf("pp%0d", i), seqP[i], 4);
        end
        bus.mode = 2'b01;
        checkStepPos("pp_left3", 3, 4);
        checkStepPos("pp_left4", 4, 4);
        bus.mode = 2'b11;
        checkStepPos("pp_snap", 2, 4);
        checkStepPos("pp_after_snap", 1, 4);

        // Pause mid-period holds pos and timer
        bus.mode = 2'b01;
        checkStepPos("pause_pre", 2, 4);
        tick1();
        bus.pause = 1'b1;
        stepSeen  = 0;
        posMoves  = 0;
        for (int c = 0; c < 10; c++) begin
            tick1();
            if (bus.step !== 1'b0) stepSeen++;
            if (bus.pos !== 3'd2) posMoves++;
        end
        bus.pause = 1'b0;
        checkOutput("pause_step_count", 32'(stepSeen), 32'd0);
        checkOutput("pause_pos_moves", 32'(posMoves), 32'd0);
        checkStepPos("pause_resume", 3, 3);

        // Pause exactly in the tick cycle delays the tick by one cycle
        tick1();
        tick1();
        tick1();
        bus.pause = 1'b1;
        tick1();
        checkOutput("pause_tick_pos", 32'(bus.pos), 32'd3);
        checkOutput("pause_tick_step", 32'(bus.step), 32'd0);
        bus.pause = 1'b0;
        tick1();
        checkOutput("unpause_tick_pos", 32'(bus.pos), 32'd4);
        checkOutput("unpause_tick_step", 32'(bus.step), 32'd1);

        // Write/read collision, out-of-range write, reset mid-scroll
        bus.mode = 2'b00;
        pulseReset();
        loadMessage();
        bus.digit_sel = 2'd2;
        applyStimulus(3'd2, 4'hF);
        checkOutput("collide_old", 32'(bus.char_out), 32'h3);
        tick1();
        checkOutput("collide_new", 32'(bus.char_out), 32'hF);
        applyStimulus(3'd7, 4'h9);
        readWindow("oob_write_read", 16'h12F4);
        bus.mode = 2'b01;
        checkStepPos("midrst_a", 1, -1);
        checkStepPos("midrst_b", 2, 4);
        bus.mode = 2'b00;
        pulseReset();
        checkOutput("midrst_pos", 32'(bus.pos), 32'd0);
        checkOutput("midrst_step", 32'(bus.step), 32'd0);
        checkOutput("midrst_char", 32'(bus.char_out), 32'd0);
        readWindow("midrst_cleared", 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/scroll_message_engine.md
# scroll_message_engine

Parametrised message scroller for the seven-segment display path: holds a writable message of `MSG_LEN` character codes and presents, for whichever digit the display multiplexer currently selects, the code for that digit inside a window of `DIGITS` characters. The window advances on a programmable tick in one of four modes (static, scroll left, scroll right, ping-pong), with pause. The block sits between the digit-scan counter and the character-to-segment decoder, and supersedes the fixed 16-character, 4-digit, left-only scroller.

## Interface
Parameters:
- `CHAR_W`, 4, width of one character code.
- `MSG_LEN`, 16, number of message entries; legal range `DIGITS` ≤ `MSG_LEN` ≤ 256 and `MSG_LEN` ≥ 2; need not be a power of two.
- `DIGITS`, 4, number of display digits; ≥ 1.
- `PERIOD`, 8388608, clock cycles per scroll tick; ≥ 1.
- Derived widths: `AW` = clog2(`MSG_LEN`), `DW` = max(1, clog2(`DIGITS`)), `TW` = max(1, clog2(`PERIOD`)).

Ports:
- `clk`  in  1  sole clock; everything is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `digit_sel`  in  `DW`  digit being scanned; 0 is the leftmost digit. Values ≥ `DIGITS` are treated as 0.
- `mode`  in  2  00 static, 01 scroll left, 10 scroll right, 11 ping-pong.
- `pause`  in  1  freezes the tick timer while high.
- `wr_en`  in  1  message write strobe.
- `wr_addr`  in  `AW`  message write index; writes with index ≥ `MSG_LEN` are ignored.
- `wr_data`  in  `CHAR_W`  character written.
- `char_out`  out  `CHAR_W`  character for `digit_sel` (registered).
- `pos`  out  `AW`  current window start index.
- `step`  out  1  one-cycle pulse in the cycle after `pos` changes.

## Operation
- Storage is a `MSG_LEN` × `CHAR_W` register array. Reset clears every entry to 0.
- A write with `wr_en`=1 and `wr_addr` < `MSG_LEN` updates that entry at the clock edge.
- Output select: `char_out` <= msg[(`pos` + `digit_sel`) mod `MSG_LEN`]. The sum is formed `AW`+1 bits wide and reduced by one conditional subtraction of `MSG_LEN`.
- Tick timer: counts 0 to `PERIOD`-1, then wraps to 0. `tick` is asserted when the count equals `PERIOD`-1 and `pause`=0. While `pause`=1 the timer holds its value. With `PERIOD`=1, `tick` is asserted every unpaused cycle.
- On `tick`:
  - Mode 00: `pos` holds.
  - Mode 01: `pos` increments; `MSG_LEN`-1 wraps to 0.
  - Mode 10: `pos` decrements; 0 wraps to `MSG_LEN`-1.
  - Mode 11 (ping-pong): uses direction flag `dir` (0 = increasing). Let `LIM` = `MSG_LEN`-`DIGITS`.
    - `dir`=0: if `pos` < `LIM`, increment `pos`; otherwise set `dir`=1 and decrement `pos`.
    - `dir`=1: if `pos` > 0, decrement `pos`; otherwise set `dir`=0 and increment `pos`.
    - If `LIM`=0, `pos` stays 0.
    - If `pos` > `LIM` at a mode-11 tick (for example after leaving mode 01), set `pos`=`LIM` and `dir`=1.
- `mode` is sampled only on `tick`; a change between ticks has no other effect and does not reset the timer or `pos`.
- `step`=1 exactly in the cycle after a tick that changed `pos`. A tick in mode 00 does not pulse `step`.

## Timing
- Reset, effective at the edge where `reset`=1: `pos`=0, `dir`=0, timer=0, `char_out`=0, `step`=0, message cleared. `reset` overrides `wr_en` and `tick` in the same cycle.
- `char_out` latency is 1 cycle from `digit_sel` and from `pos`.
- Write in cycle N is visible on `char_out` in cycle N+2 at the earliest. A same-cycle write and read of the same entry returns the old value.
- `pos` updates at the edge that ends the tick cycle; the first tick after reset occurs `PERIOD` cycles after reset deasserts.
- Asserting `pause` in the cycle the timer would tick suppresses that tick. The tick then fires on the first unpaused cycle.

## Test plan
Bench parameters: `MSG_LEN`=6, `DIGITS`=4, `PERIOD`=4; message loaded with 1,2,3,4,5,6 at indices 0–5.
1. Reset, mode 00, scan `digit_sel` 0–3 → `char_out` = 1,2,3,4, each one cycle late; `pos` stays 0 for 20 cycles; `step` is never asserted.
2. Mode 01 for 7 ticks → `pos` = 1,2,3,4,5,0,1, one step every 4 cycles, with `step` pulsing each time. At `pos`=4, digits 0–3 read 5,6,1,2 (wrap).
3. Mode 10 from `pos`=0 → `pos` = 5,4,3; digits at `pos`=5 read 6,1,2,3.
4. Mode 11 from reset → `pos` = 1,2,1,0,1,2. Then switch to 01 until `pos`=4, then back to 11 → next tick gives `pos`=2 with `dir`=1.
5. `pause` high for 10 cycles mid-period → `pos` and timer frozen; the tick resumes with the remaining count preserved.
6. Write 0xF to index 2 while `digit_sel` reads that entry → old value (3) shown first, then 0xF two cycles after the write. A write to `wr_addr`=7 is ignored. `reset` mid-scroll clears `pos` and the message at the next edge.
